// File: rtl/dmem_io_pkg.sv
// Shared address map and region select for the data-side memory/IO stage.
// Timer registers exist only when DMEM_IO_TIMER_EN is defined.
package dmem_io_pkg;

    localparam logic [31:0] IO_BASE     = 32'hFFFF_0000;
    localparam logic [31:0] LED_ADDR    = IO_BASE + 32'h0;
    localparam logic [31:0] SW_ADDR     = IO_BASE + 32'h4;
    localparam logic [31:0] TCOUNT_ADDR = IO_BASE + 32'h8;
    localparam logic [31:0] TCMP_ADDR   = IO_BASE + 32'hC;
    localparam logic [31:0] STATUS_ADDR = IO_BASE + 32'h10;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_LED,
        SEL_SW,
        SEL_TCOUNT,
        SEL_TCMP,
        SEL_STATUS,
        SEL_NONE
    } sel_e;

    // Word-granular match; the byte offset never takes part.
    function automatic logic word_hit(
        input logic [31:0] a,
        input logic [31:0] base
    );
        return a[31:2] == base[31:2];
    endfunction

endpackage

// File: rtl/io_timer.sv
// Free-running timer with compare, auto-reload to zero and a sticky match flag.
// Instantiated by dmem_io only when DMEM_IO_TIMER_EN is defined.
module io_timer
    import dmem_io_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wdata,
    input  logic        we_count,
    input  logic        we_cmp,
    input  logic        we_status,
    output logic [31:0] count,
    output logic [31:0] cmp,
    output logic        flag
);

    logic match;

    assign match = (cmp != '0) && (count == cmp);

    // Count write and match both zero the count; a match beats a flag clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            cmp   <= '0;
            flag  <= 1'b0;
        end else begin
            if (we_count || match) begin
                count <= '0;
            end else begin
                count <= count + 32'd1;
            end
            if (we_cmp) begin
                cmp <= wdata;
            end
            if (match) begin
                flag <= 1'b1;
            end else if (we_status && wdata[0]) begin
                flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dmem_io.sv
// Data RAM plus memory-mapped LED, switch and (with DMEM_IO_TIMER_EN) timer.
// Loads are combinational; stores commit on the rising clock edge.
module dmem_io
    import dmem_io_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int SW_W  = 8,
    parameter int LED_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [31:0]      addr,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] led,
    output logic             irq
);

    localparam int AW = $clog2(DEPTH);

    sel_e            sel;
    logic [AW-1:0]   widx;
    logic [31:0]     mem [DEPTH];
    logic [LED_W-1:0] led_q;
    logic [SW_W-1:0] sw_s1;
    logic [SW_W-1:0] sw_s2;
    logic            unused_addr;

    assign widx        = addr[AW+1:2];
    assign unused_addr = ^addr[1:0];

    always_comb begin
        sel = SEL_NONE;
        if (addr[31:AW+2] == '0) begin
            sel = SEL_RAM;
        end else if (word_hit(addr, LED_ADDR)) begin
            sel = SEL_LED;
        end else if (word_hit(addr, SW_ADDR)) begin
            sel = SEL_SW;
`ifdef DMEM_IO_TIMER_EN
        end else if (word_hit(addr, TCOUNT_ADDR)) begin
            sel = SEL_TCOUNT;
        end else if (word_hit(addr, TCMP_ADDR)) begin
            sel = SEL_TCMP;
        end else if (word_hit(addr, STATUS_ADDR)) begin
            sel = SEL_STATUS;
`endif
        end
    end

    // RAM has no reset; a store coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (memwrite && !reset && sel == SEL_RAM) begin
            mem[widx] <= writedata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q <= '0;
        end else if (memwrite && sel == SEL_LED) begin
            led_q <= writedata[LED_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
        end
    end

    assign led = led_q;

`ifdef DMEM_IO_TIMER_EN
    logic [31:0] tcount;
    logic [31:0] tcmp;
    logic        tflag;

    io_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .wdata     (writedata),
        .we_count  (memwrite && sel == SEL_TCOUNT),
        .we_cmp    (memwrite && sel == SEL_TCMP),
        .we_status (memwrite && sel == SEL_STATUS),
        .count     (tcount),
        .cmp       (tcmp),
        .flag      (tflag)
    );

    assign irq = tflag;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        unique case (sel)
            SEL_RAM:    readdata = mem[widx];
            SEL_LED:    readdata[LED_W-1:0] = led_q;
            SEL_SW:     readdata[SW_W-1:0] = sw_s2;
`ifdef DMEM_IO_TIMER_EN
            SEL_TCOUNT: readdata = tcount;
            SEL_TCMP:   readdata = tcmp;
            SEL_STATUS: readdata[0] = tflag;
`endif
            default:    readdata = '0;
        endcase
    end

endmodule

// File: doc/dmem_io.md
# dmem_io

Data-side memory and memory-mapped I/O stage for the single-cycle MIPS core. It consumes the datapath's ALU result as address and its store data, decodes the address into word RAM or peripheral registers, and returns `readdata` combinationally in the same cycle, as the single-cycle datapath requires. Peripherals are:

- an LED output register
- a synchronised switch input
- a free-running timer with compare and a sticky match flag

## Interface
Parameters:
- `DEPTH`, 64: data RAM size in 32-bit words; power of two, at least 4.
- `SW_W`, 8: switch input width.
- `LED_W`, 8: LED output width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `memwrite`  in  1  store strobe from the controller.
- `addr`  in  32  byte address (the datapath's `aluout`).
- `writedata`  in  32  store data.
- `readdata`  out  32  load data, combinational.
- `sw`  in  SW_W  asynchronous board switches.
- `led`  out  LED_W  LED register contents.
- `irq`  out  1  mirror of the timer match flag.

## Operation
- `addr[1:0]` is ignored. All accesses are full words.
- Address map:
  - RAM: `0x0000_0000` to `DEPTH*4-1`.
  - LED: `0xFFFF_0000`, R/W. Low LED_W bits are stored; upper bits read as 0.
  - SW: `0xFFFF_0004`, read-only. Synchronised value is zero-extended; writes are ignored.
  - TCOUNT: `0xFFFF_0008`. Read returns the count; any write clears the count to 0.
  - TCMP: `0xFFFF_000C`, R/W.
  - STATUS: `0xFFFF_0010`. Bit0 is the match flag; a write with `writedata[0]=1` clears it. Other bits read as 0.
- Unmapped addresses: reads return `0x0000_0000`; writes are dropped with no side effects.
- Read path is purely combinational from the current `addr` and the state registers. There is no read-side state.
- Writes commit on the rising edge of `clk` when `memwrite=1`.
- Switch path: two-flop synchronizer, with no debounce.
- Timer behaviour:
  - TCOUNT increments by 1 every cycle and wraps `0xFFFF_FFFF` to 0.
  - If TCMP≠0 and TCOUNT==TCMP, then on the next edge TCOUNT becomes 0 and the flag becomes 1.
  - TCMP=0 disables matching.
- Simultaneous events:
  - A TCOUNT write together with a match: the write wins. Count becomes 0 and the flag is still set.
  - A STATUS clear together with a match: the set wins.
  - A TCMP write takes effect for the comparison on the following cycle.
- `irq` = flag.

## Timing
- `readdata` is valid in the same cycle as `addr`. There is no latency.
- Write-then-read of the same location: the new value is visible in the cycle after the write edge.
- `sw` to SW read latency: 2 clock edges. Value is stable from the third cycle.
- Timer, with TCMP=N written at edge 0 and count 0:
  - Count reaches N after N further edges.
  - The flag sets on the next edge.
  - Period is N+1 cycles.
- Reset values: `led`=0, sync flops=0, TCOUNT=0, TCMP=0, flag=0, `irq`=0.
  - RAM is not reset and its contents are undefined.
  - `readdata` during reset reflects the reset register values for mapped I/O addresses.
- Reset asserted mid-operation clears all registers immediately. A write in the same cycle is lost.

## Configuration
- `DMEM_IO_TIMER_EN` defined: timer, TCOUNT, TCMP, STATUS and `irq` are present as above.
- `DMEM_IO_TIMER_EN` undefined:
  - Timer logic is removed.
  - `0xFFFF_0008` to `0xFFFF_0010` become unmapped: they read 0 and writes are dropped.
  - `irq` is tied to 0.

## Structure
- `dmem_io_pkg` holds:
  - Address constants: `IO_BASE`, `LED_ADDR`, `SW_ADDR`, `TCOUNT_ADDR`, `TCMP_ADDR`, `STATUS_ADDR`.
  - The region-select enum: RAM, LED, SW, TCOUNT, TCMP, STATUS, NONE.
- One sub-module, `io_timer`, holds the count, compare, flag and match logic, with write-enable inputs per register. It is instantiated under the macro.
- The address decoder and read mux stay in `dmem_io`.

## Test plan
- Reset, then read LED, SW (with `sw`=0), TCOUNT, TCMP and STATUS → all return 0. `led`=0 and `irq`=0.
- RAM: write `0xDEADBEEF` at `0x0000_0010`, then read `0x0000_0010` and `0x0000_0013` → both return `0xDEADBEEF`. Read `0x0000_0014` → the unaffected word.
- LED: write `0x0000_01A5` to `0xFFFF_0000` → `led`=`0xA5` and a read returns `0x0000_00A5`. A write to `0x0000_8000` (unmapped) → reads 0 and no state changes.
- Switches: `sw` steps 0→`0x3C` → SW read is still 0 after 1 edge and `0x0000_003C` after 2 edges.
- Timer:
  - Write TCMP=5 → the flag rises 6 cycles later, TCOUNT returns to 0, and it repeats every 6 cycles.
  - A STATUS write of 1 in the match cycle → the flag stays 1.
  - A TCOUNT write mid-count → the count is 0 on the next cycle.
- Build without `DMEM_IO_TIMER_EN` → reads at `0xFFFF_0008`, `0xFFFF_000C` and `0xFFFF_0010` return 0, and `irq` stays 0 for 100 cycles.
